keccak_absorb_unit: RTL and testbench

//  Absorb stage of the Keccak/SHA-3 engine. XORs one 256-bit message beat into the rate portion
//  of the 5x5x64 state, starting at the current byte offset, and reports the new offset.

---
 rtl/keccak_absorb_unit.sv | 131 +++++++++++++
 tb/tb_keccak_absorb_unit.sv | 202 ++++++++++++++++++++
 2 files changed

// File: rtl/keccak_absorb_unit.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | keccak_absorb_unit: XORs one message beat into the Keccak rate region at |
// | a byte offset, returns leftover bytes as a carry beat.   Rev 1.0         |
// +--------------------------------------------------------------------------+
module keccak_absorb_unit #(
  parameter int ROW_SIZE          = 5,
  parameter int COL_SIZE          = 5,
  parameter int LANE_SIZE         = 64,
  parameter int DWIDTH            = 256,
  parameter int KEEP_WIDTH        = 32,
  parameter int RATE_WIDTH        = 11,
  parameter int BYTE_ABSORB_WIDTH = 8
) (
  input  logic                                              clk_i,
  input  logic                                              rst_ni,
  input  logic                                              valid_i,
  input  logic [ROW_SIZE-1:0][COL_SIZE-1:0][LANE_SIZE-1:0]  state_array_i,
  input  logic [RATE_WIDTH-1:0]                             rate_i,
  input  logic [BYTE_ABSORB_WIDTH-1:0]                      bytes_absorbed_i,
  input  logic [DWIDTH-1:0]                                 msg_i,
  input  logic [KEEP_WIDTH-1:0]                             keep_i,
  output logic                                              valid_o,
  output logic [ROW_SIZE-1:0][COL_SIZE-1:0][LANE_SIZE-1:0]  state_array_o,
  output logic [BYTE_ABSORB_WIDTH-1:0]                      bytes_absorbed_o,
  output logic [DWIDTH-1:0]                                 carry_over_o,
  output logic                                              has_carry_over_o,
  output logic [KEEP_WIDTH-1:0]                             carry_keep_o
);

  localparam int STATE_W = ROW_SIZE * COL_SIZE * LANE_SIZE;
  localparam int N_W     = $clog2(KEEP_WIDTH + 1);
  localparam int BAW     = BYTE_ABSORB_WIDTH;

  logic [N_W-1:0]        w_n;
  logic [N_W-1:0]        w_take;
  logic [KEEP_WIDTH-1:0] w_nmask;
  logic [DWIDTH-1:0]     w_msg_n;
  logic [DWIDTH-1:0]     w_msg_take;
  logic [BAW-1:0]        w_rate_bytes;
  logic [BAW-1:0]        w_space;
  logic [STATE_W-1:0]    w_flat;
  logic [STATE_W-1:0]    w_flat_new;
  logic                  w_run;
  logic                  w_unused_rate;

  logic [ROW_SIZE-1:0][COL_SIZE-1:0][LANE_SIZE-1:0] state_d, state_q;
  logic [BAW-1:0]        bytes_absorbed_d, bytes_absorbed_q;
  logic [DWIDTH-1:0]     carry_d, carry_q;
  logic                  has_carry_d, has_carry_q;
  logic [KEEP_WIDTH-1:0] carry_keep_d, carry_keep_q;
  logic                  valid_q;

  // Rates are always whole bytes, so the low three bits carry no information.
  assign w_unused_rate = ^rate_i[2:0];
  assign w_rate_bytes  = rate_i[RATE_WIDTH-1:3];
  assign w_space       = (bytes_absorbed_i >= w_rate_bytes) ? '0 : (w_rate_bytes - bytes_absorbed_i);

  always_comb begin
    w_n   = '0;
    w_run = 1'b1;
    for (int j = 0; j < KEEP_WIDTH; j++) begin
      if (w_run && keep_i[j]) w_n = w_n + 1'b1;
      else                    w_run = 1'b0;
    end
  end

  assign w_take = (BAW'(w_n) < w_space) ? w_n : w_space[N_W-1:0];

  always_comb begin
    w_nmask    = '0;
    w_msg_n    = '0;
    w_msg_take = '0;
    for (int j = 0; j < KEEP_WIDTH; j++) begin
      w_nmask[j] = (N_W'(j) < w_n);
      if (w_nmask[j])            w_msg_n[8*j +: 8]    = msg_i[8*j +: 8];
      if (N_W'(j) < w_take)      w_msg_take[8*j +: 8] = msg_i[8*j +: 8];
    end
  end

  // Lane L = x + 5y occupies flat bits [64L +: 64]; this is the byte order of the rate.
  always_comb begin
    w_flat = '0;
    for (int x = 0; x < ROW_SIZE; x++)
      for (int y = 0; y < COL_SIZE; y++)
        w_flat[(x + ROW_SIZE*y)*LANE_SIZE +: LANE_SIZE] = state_array_i[x][y];
  end

  assign w_flat_new = w_flat ^ (STATE_W'(w_msg_take) << {bytes_absorbed_i, 3'b000});

  always_comb begin
    state_d = '0;
    for (int x = 0; x < ROW_SIZE; x++)
      for (int y = 0; y < COL_SIZE; y++)
        state_d[x][y] = w_flat_new[(x + ROW_SIZE*y)*LANE_SIZE +: LANE_SIZE];
  end

  assign bytes_absorbed_d = bytes_absorbed_i + BAW'(w_take);
  assign has_carry_d      = (BAW'(w_n) > w_space);
  assign carry_d          = has_carry_d ? (w_msg_n >> {w_space, 3'b000}) : '0;
  assign carry_keep_d     = has_carry_d ? (w_nmask >> w_space) : '0;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      valid_q          <= 1'b0;
      state_q          <= '0;
      bytes_absorbed_q <= '0;
      carry_q          <= '0;
      has_carry_q      <= 1'b0;
      carry_keep_q     <= '0;
    end else begin
      valid_q <= valid_i;
      if (valid_i) begin
        state_q          <= state_d;
        bytes_absorbed_q <= bytes_absorbed_d;
        carry_q          <= carry_d;
        has_carry_q      <= has_carry_d;
        carry_keep_q     <= carry_keep_d;
      end
    end
  end

  assign valid_o          = valid_q;
  assign state_array_o    = state_q;
  assign bytes_absorbed_o = bytes_absorbed_q;
  assign carry_over_o     = carry_q;
  assign has_carry_over_o = has_carry_q;
  assign carry_keep_o     = carry_keep_q;

endmodule
`default_nettype wire

// File: tb/tb_keccak_absorb_unit.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_keccak_absorb_unit: directed + random bench with byte-level model.    |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
module tb_keccak_absorb_unit;

  typedef logic [4:0][4:0][63:0] st_t;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         valid_in = 1'b0;
  st_t          state_in = '0;
  logic [10:0]  rate_in = '0;
  logic [7:0]   off_in = '0;
  logic [255:0] msg_in = '0;
  logic [31:0]  keep_in = '0;
  logic         valid_out;
  st_t          state_out;
  logic [7:0]   off_out;
  logic [255:0] carry_out;
  logic         has_out;
  logic [31:0]  ckeep_out;

  st_t          exp_st;
  logic [7:0]   exp_off;
  logic [255:0] exp_carry;
  logic         exp_has;
  logic [31:0]  exp_keep;

  int n_checks = 0;
  int n_fail   = 0;

  int unsigned rates [5] = '{576, 832, 1088, 1152, 1344};

  keccak_absorb_unit dut (
    .clk_i            (clk),
    .rst_ni           (rst_n),
    .valid_i          (valid_in),
    .state_array_i    (state_in),
    .rate_i           (rate_in),
    .bytes_absorbed_i (off_in),
    .msg_i            (msg_in),
    .keep_i           (keep_in),
    .valid_o          (valid_out),
    .state_array_o    (state_out),
    .bytes_absorbed_o (off_out),
    .carry_over_o     (carry_out),
    .has_carry_over_o (has_out),
    .carry_keep_o     (ckeep_out)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Byte-array view: state byte k sits in lane k/8, x=(k/8)%5, y=(k/8)/5.
  task automatic model(input st_t st, input int rate, input int off,
                       input logic [255:0] msg, input logic [31:0] keep);
    int n, r, space, take, c, k, lane;
    n = 0;
    while (n < 32 && keep[n]) n++;
    r     = rate / 8;
    space = (off >= r) ? 0 : r - off;
    take  = (n < space) ? n : space;
    exp_st = st;
    for (int j = 0; j < take; j++) begin
      k    = off + j;
      lane = k / 8;
      exp_st[lane % 5][lane / 5][8*(k % 8) +: 8] =
        exp_st[lane % 5][lane / 5][8*(k % 8) +: 8] ^ msg[8*j +: 8];
    end
    exp_off   = 8'(off + take);
    c         = (n > space) ? n - space : 0;
    exp_has   = (c > 0);
    exp_carry = '0;
    exp_keep  = '0;
    for (int i = 0; i < c; i++) begin
      exp_carry[8*i +: 8] = msg[8*(space + i) +: 8];
      exp_keep[i]         = 1'b1;
    end
  endtask

  task automatic compare_all(input string tag, input logic exp_valid);
    check({tag, ".valid"}, 256'(valid_out), 256'(exp_valid));
    for (int x = 0; x < 5; x++)
      for (int y = 0; y < 5; y++)
        check($sformatf("%s.lane[%0d][%0d]", tag, x, y), 256'(state_out[x][y]), 256'(exp_st[x][y]));
    check({tag, ".offset"}, 256'(off_out), 256'(exp_off));
    check({tag, ".has_carry"}, 256'(has_out), 256'(exp_has));
    check({tag, ".carry"}, carry_out, exp_carry);
    check({tag, ".carry_keep"}, 256'(ckeep_out), 256'(exp_keep));
  endtask

  task automatic apply(input string tag, input st_t st, input int rate, input int off,
                       input logic [255:0] msg, input logic [31:0] keep);
    @(negedge clk);
    state_in = st; rate_in = 11'(rate); off_in = 8'(off); msg_in = msg; keep_in = keep;
    valid_in = 1'b1;
    model(st, rate, off, msg, keep);
    @(posedge clk); #1;
    valid_in = 1'b0;
    compare_all(tag, 1'b1);
  endtask

  task automatic check_zero(input string tag);
    exp_st = '0; exp_off = '0; exp_carry = '0; exp_has = 1'b0; exp_keep = '0;
    compare_all(tag, 1'b0);
  endtask

  function automatic logic [255:0] rnd256();
    logic [255:0] v;
    for (int i = 0; i < 8; i++) v[32*i +: 32] = $urandom;
    return v;
  endfunction

  function automatic st_t rnd_state();
    st_t s;
    for (int x = 0; x < 5; x++)
      for (int y = 0; y < 5; y++) s[x][y] = {$urandom, $urandom};
    return s;
  endfunction

  initial begin
    logic [63:0]  pa, pb, pc;
    logic [255:0] m;
    int r, nb;

    repeat (2) @(posedge clk);
    #1 check_zero("reset");
    @(negedge clk) rst_n = 1'b1;

    pa = 64'h1111_2222_3333_4444;
    apply("t1", '0, 1088, 0, {4{pa}}, 32'hFFFF_FFFF);
    check("t1.x3y0", 256'(state_out[3][0]), 256'(pa));
    check("t1.off", 256'(off_out), 256'd32);

    pa = {16{4'hA}}; pb = {16{4'hB}};
    apply("t2", '0, 1088, 128, {{3{pb}}, pa}, 32'hFFFF_FFFF);
    check("t2.x1y3", 256'(state_out[1][3]), 256'(pa));
    check("t2.off", 256'(off_out), 256'd136);
    check("t2.carry", carry_out, {64'd0, {3{pb}}});
    check("t2.ckeep", 256'(ckeep_out), 256'h00FF_FFFF);

    pc = {16{4'hC}};
    apply("t3", '0, 576, 64, {4{pc}}, 32'hFFFF_FFFF);
    check("t3.x3y1", 256'(state_out[3][1]), 256'(pc));
    check("t3.off", 256'(off_out), 256'd72);

    m = rnd256(); m[63:0] = 64'h9999_8888_7777_6666;
    apply("t4", '0, 1344, 160, m, 32'hFFFF_FFFF);
    check("t4.x0y4", 256'(state_out[0][4]), 256'h9999_8888_7777_6666);
    check("t4.off", 256'(off_out), 256'd168);
    check("t4.carry", carry_out, {64'd0, m[255:64]});

    apply("t5a", '0, 1088, 24, rnd256(), 32'hFFFF_FFFF);
    check("t5a.off", 256'(off_out), 256'd56);

    m = rnd256(); m[39:0] = 40'hAA_BBCC_DDEE;
    apply("t5b", '0, 1088, 0, m, 32'h0000_001F);
    check("t5b.x0y0", 256'(state_out[0][0]), 256'h0000_00AA_BBCC_DDEE);
    check("t5b.off", 256'(off_out), 256'd5);

    apply("t6", '0, 1088, 0, {{31{8'hFF}}, 8'hAA}, 32'h0000_0001);
    check("t6.x0y0", 256'(state_out[0][0]), 256'h0000_0000_0000_00AA);
    check("t6.off", 256'(off_out), 256'd1);

    // Idle cycle with garbage inputs: data must hold, valid must drop.
    @(negedge clk);
    state_in = rnd_state(); msg_in = rnd256(); keep_in = 32'hFFFF_FFFF; off_in = 8'd3;
    @(posedge clk); #1;
    compare_all("hold", 1'b0);

    apply("zero_keep", rnd_state(), 832, 40, rnd256(), 32'h0);
    apply("off_at_rate", rnd_state(), 576, 72, rnd256(), 32'hFFFF_FFFF);

    for (int t = 0; t < 150; t++) begin
      r  = int'(rates[$urandom_range(0, 4)]);
      nb = $urandom_range(0, 32);
      apply($sformatf("rnd%0d", t), rnd_state(), r, $urandom_range(0, r / 8),
            rnd256(), 32'((33'd1 << nb) - 33'd1));
    end

    // Asynchronous reset between edges.
    apply("pre_rst", rnd_state(), 1088, 10, rnd256(), 32'hFFFF_FFFF);
    #2 rst_n = 1'b0;
    #1 check_zero("async_rst");
    @(negedge clk) rst_n = 1'b1;
    apply("post_rst", rnd_state(), 1152, 130, rnd256(), 32'h00FF_FFFF);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
